complex_mult_datapath: RTL
==========================

Name: complex_mult_datapath

Overview:
- Arithmetic datapath driven by the complex-multiplier control unit's strobes (a_sel, b_sel, PP1_CE, PP2_CE, add, PR_CE, PI_CE).
- Uses one time-shared signed multiplier over a repeating 5-cycle frame to compute PR = ar·br − ai·bi and PI = ar·bi + ai·br.
- Adds a valid/ready operand-capture port, a 1-cycle result-valid pulse, and a strobe-sequence checker that flags a misbehaving controller.

Parameters:
- W, 8, signed operand width (each real/imag input)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ar, ai, br, bi  in  W each  signed operands A = ar + j·ai, B = br + j·bi
- in_valid  in  1  operands present
- in_ready  out  1  operand registers can accept
- a_sel  in  1  multiplier A-mux: 0 = ar, 1 = ai
- b_sel  in  1  multiplier B-mux: 0 = br, 1 = bi
- PP1_CE, PP2_CE  in  1 each  partial-product register enables
- add  in  1  combiner mode: 1 = PP1 − PP2, 0 = PP1 + PP2
- PR_CE, PI_CE  in  1 each  result register enables
- PR, PI  out  2W+1 each  signed real/imag results
- out_valid  out  1  one-cycle pulse: PR/PI hold a complete new result
- seq_err  out  1  sticky controller-sequence error

Behaviour:
- Reset (async): operand regs, PP1, PP2, PR, PI = 0; op_full = 0; out_valid = 0; seq_err = 0; tracker = P1.
  - Reset mid-frame discards the held operands and the partial result.
- Multiplier is combinational: product = mux(a_sel) × mux(b_sel), full 2W signed.
  - PP1/PP2 load the product on the edge where their CE = 1.
- Combiner: sign-extend PP1 and PP2 to 2W+1, then add or subtract per the add input.
  - PR loads on PR_CE; PI loads on PI_CE. No saturation; 2W+1 bits cannot overflow.
- Expected strobe phases (all other strobes 0):
  - P1: PP1_CE, sel 00
  - P2: PP2_CE, sel 11
  - P3: PP1_CE, PR_CE, add, a_sel = 0, b_sel = 1
  - P4: PP2_CE, a_sel = 1, b_sel = 0
  - P5: PI_CE
  - After P5, return to P1. The tracker advances one phase per cycle.
- Frame start: tracker at P1, op_full = 1, and the P1 pattern is present → frame active.
  - With op_full = 0 the strobes are still applied, but the frame is idle and produces no out_valid.
- Frame end: P5 of an active frame → out_valid = 1 in the following cycle. op_full clears unless a new accept occurs on the same edge.
- in_ready = !op_full || (active frame && tracker == P5).
  - Accept = in_valid && in_ready; operands load on that edge and op_full is set.
  - Operands never change between P1 and P4 of an active frame. Back-to-back throughput is one result per 5 cycles.
- Result latency: accept to out_valid is 6 cycles minimum (accept during P5 of the prior frame).
- PR updates at P3 and stays stable until the next P3. PI updates at P5.
  - During the out_valid cycle both PR and PI belong to the same operands.

Optional Feature:
- Macro SEQ_CHECK_EN.
- Defined:
  - Any mismatch against the expected phase pattern sets seq_err (sticky until rst) and aborts an active frame: no out_valid, op_full retained.
  - The tracker resynchronises: a P1 pattern forces it to P2; otherwise it waits in P1.
- Undefined:
  - seq_err is tied 0.
  - The tracker is a free-running mod-5 counter, resynchronised only by reset.
  - Frame end = PI_CE while the frame is active.

Decomposition:
- Package complex_mult_pkg:
  - phase encodings P1..P5 (3-bit)
  - expected strobe-pattern constants per phase, as a 7-bit vector {a_sel, b_sel, PP1_CE, PP2_CE, add, PR_CE, PI_CE}
  - W default
- Sub-module complex_mult_seq_checker: phase tracker, pattern compare, seq_err. Consumed by the top-level datapath.

Test Plan:
- W = 8, accept (3+4j)·(5+6j), drive a correct 5-phase frame → out_valid one cycle after P5, PR = −9, PI = 38.
- (−128−128j)·(−128−128j) → PR = 0, PI = 32768 (17-bit, no overflow).
- Three back-to-back accepts, each during P5 → out_valid every 5 cycles; results (1+0j)(2+0j) = 2+0j, (0+1j)(0+1j) = −1+0j, (−1+2j)(3−4j) = 5+10j.
- in_valid low for 12 cycles while the controller loops → no out_valid, in_ready held 1, PR/PI unchanged after the last frame.
- SEQ_CHECK_EN, corrupt P3 (add = 0) → seq_err = 1 next cycle, no out_valid; the next clean frame with the same operands yields the correct result, seq_err stays 1.
- Assert rst during P4 of an active frame → all outputs 0 immediately, in_ready = 1, no out_valid after rst release.

Source files
------------

// File: rtl/complex_mult_pkg.sv
// Shared phase encodings and expected strobe patterns for the time-shared complex multiplier.
package complex_mult_pkg;

    localparam int W_DEF = 8;
    localparam int STB_W = 7;

    typedef enum logic [2:0] {
        PH_P1 = 3'd0,
        PH_P2 = 3'd1,
        PH_P3 = 3'd2,
        PH_P4 = 3'd3,
        PH_P5 = 3'd4
    } phase_t;

    // Strobe vector order: {a_sel, b_sel, PP1_CE, PP2_CE, add, PR_CE, PI_CE}
    localparam logic [STB_W-1:0] PAT_P1 = 7'b0010000;
    localparam logic [STB_W-1:0] PAT_P2 = 7'b1101000;
    localparam logic [STB_W-1:0] PAT_P3 = 7'b0110110;
    localparam logic [STB_W-1:0] PAT_P4 = 7'b1001000;
    localparam logic [STB_W-1:0] PAT_P5 = 7'b0000001;

    function automatic logic [STB_W-1:0] exp_pattern(input phase_t ph);
        logic [STB_W-1:0] pat;
        case (ph)
            PH_P1:   pat = PAT_P1;
            PH_P2:   pat = PAT_P2;
            PH_P3:   pat = PAT_P3;
            PH_P4:   pat = PAT_P4;
            PH_P5:   pat = PAT_P5;
            default: pat = '0;
        endcase
        return pat;
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_P1:   nxt = PH_P2;
            PH_P2:   nxt = PH_P3;
            PH_P3:   nxt = PH_P4;
            PH_P4:   nxt = PH_P5;
            default: nxt = PH_P1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/complex_mult_seq_checker.sv
// Phase tracker for the controller strobes; with SEQ_CHECK_EN it compares each cycle's
// strobes against the expected pattern, resynchronises on mismatch and keeps a sticky error.
module complex_mult_seq_checker
    import complex_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [STB_W-1:0] i_strobes,
    output phase_t           o_phase,
    output logic             o_p1_seen,
    output logic             o_mismatch,
    output logic             o_seq_err
);

    phase_t r_phase;
    phase_t w_phase_nxt;

    assign o_p1_seen = (i_strobes == PAT_P1);

`ifdef SEQ_CHECK_EN
    logic r_seq_err;
    logic w_mismatch;

    assign w_mismatch = (i_strobes != exp_pattern(r_phase));

    // A stray P1 pattern is taken as the controller restarting, so skip ahead to P2.
    always_comb begin
        w_phase_nxt = next_phase(r_phase);
        if (w_mismatch) begin
            w_phase_nxt = o_p1_seen ? PH_P2 : PH_P1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_err <= 1'b0;
        end else if (w_mismatch) begin
            r_seq_err <= 1'b1;
        end
    end

    assign o_mismatch = w_mismatch;
    assign o_seq_err  = r_seq_err;
`else
    assign w_phase_nxt = next_phase(r_phase);
    assign o_mismatch  = 1'b0;
    assign o_seq_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_P1;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/complex_mult_datapath.sv
// Complex multiply over a 5-cycle frame on one shared multiplier; one result per 5 cycles,
// operands accepted when empty or during P5 of an active frame. Optional SEQ_CHECK_EN.
module complex_mult_datapath
    import complex_mult_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] ar,
    input  logic signed [W-1:0] ai,
    input  logic signed [W-1:0] br,
    input  logic signed [W-1:0] bi,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                a_sel,
    input  logic                b_sel,
    input  logic                PP1_CE,
    input  logic                PP2_CE,
    input  logic                add,
    input  logic                PR_CE,
    input  logic                PI_CE,
    output logic signed [2*W:0] PR,
    output logic signed [2*W:0] PI,
    output logic                out_valid,
    output logic                seq_err
);

    logic signed [W-1:0]   r_ar, r_ai, r_br, r_bi;
    logic signed [2*W-1:0] r_pp1, r_pp2;
    logic signed [2*W:0]   r_pr, r_pi;
    logic                  r_op_full, r_active, r_out_valid;

    logic [STB_W-1:0]      w_strobes;
    phase_t                w_phase;
    logic                  w_p1_seen, w_mismatch, w_seq_err;
    logic                  w_start, w_abort, w_end, w_in_ready, w_accept;
    logic signed [W-1:0]   w_mul_a, w_mul_b;
    logic signed [2*W-1:0] w_mul_a_x, w_mul_b_x, w_prod;
    logic signed [2*W:0]   w_pp1_x, w_pp2_x, w_comb;

    assign w_strobes = {a_sel, b_sel, PP1_CE, PP2_CE, add, PR_CE, PI_CE};

    complex_mult_seq_checker u_seq (
        .clk        (clk),
        .rst        (rst),
        .i_strobes  (w_strobes),
        .o_phase    (w_phase),
        .o_p1_seen  (w_p1_seen),
        .o_mismatch (w_mismatch),
        .o_seq_err  (w_seq_err)
    );

    assign w_start = (w_phase == PH_P1) && r_op_full && w_p1_seen;
    assign w_abort = r_active && w_mismatch;
`ifdef SEQ_CHECK_EN
    assign w_end   = r_active && (w_phase == PH_P5) && !w_mismatch;
`else
    assign w_end   = r_active && PI_CE;
`endif

    // Loading during P5 is safe: PP1/PP2 are already captured and P1 re-reads the new operands.
    assign w_in_ready = !r_op_full || (r_active && (w_phase == PH_P5));
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_full   <= 1'b0;
            r_active    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_end;
            if (w_accept) begin
                r_op_full <= 1'b1;
            end else if (w_end) begin
                r_op_full <= 1'b0;
            end
            if (w_end || w_abort) begin
                r_active <= 1'b0;
            end else if (w_start) begin
                r_active <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar <= '0;
            r_ai <= '0;
            r_br <= '0;
            r_bi <= '0;
        end else if (w_accept) begin
            r_ar <= ar;
            r_ai <= ai;
            r_br <= br;
            r_bi <= bi;
        end
    end

    assign w_mul_a   = a_sel ? r_ai : r_ar;
    assign w_mul_b   = b_sel ? r_bi : r_br;
    assign w_mul_a_x = {{W{w_mul_a[W-1]}}, w_mul_a};
    assign w_mul_b_x = {{W{w_mul_b[W-1]}}, w_mul_b};
    assign w_prod    = w_mul_a_x * w_mul_b_x;

    assign w_pp1_x = {r_pp1[2*W-1], r_pp1};
    assign w_pp2_x = {r_pp2[2*W-1], r_pp2};
    assign w_comb  = add ? (w_pp1_x - w_pp2_x) : (w_pp1_x + w_pp2_x);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pp1 <= '0;
            r_pp2 <= '0;
            r_pr  <= '0;
            r_pi  <= '0;
        end else begin
            if (PP1_CE) r_pp1 <= w_prod;
            if (PP2_CE) r_pp2 <= w_prod;
            if (PR_CE)  r_pr  <= w_comb;
            if (PI_CE)  r_pi  <= w_comb;
        end
    end

    assign in_ready  = w_in_ready;
    assign PR        = r_pr;
    assign PI        = r_pi;
    assign out_valid = r_out_valid;
    assign seq_err   = w_seq_err;

endmodule
